btn_event_scheduler: RTL and testbench

BTN_EVENT_SCHEDULER -- requirements
Module: btn_event_scheduler

---
 rtl/fpww_pkg.sv | 20 ++
 rtl/btn_repeat_fsm.sv | 77 +++++++
 rtl/btn_event_scheduler.sv | 118 +++++++++++
 tb/tb_btn_event_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fpww_pkg.sv
// Shared types and defaults for the button event scheduler.
package fpww_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

    localparam int DEF_N_BTN    = 3;
    localparam int DEF_HOLD_CYC = 50_000_000;
    localparam int DEF_RATE_CYC = 10_000_000;
    localparam int DEF_CNT_W    = 26;

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/btn_repeat_fsm.sv
// Per-button press / auto-repeat generator: emits a one-cycle event strobe
// on the first press, after the hold delay, and then at the repeat rate.
module btn_repeat_fsm
    import fpww_pkg::*;
#(
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int RATE_CYC = DEF_RATE_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic uclock,
    input  logic uresetn,
    input  logic btn,
    output logic evt,
    output logic evt_rpt
);

    // cnt holds the number of held samples since the press, so the first
    // repeat fires exactly HOLD_CYC cycles after the press event.
    localparam logic [CNT_W-1:0] HOLD_HIT = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] RATE_HIT = CNT_W'(RATE_CYC - 1);

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge uclock or negedge uresetn) begin
        if (!uresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt     = 1'b0;
        evt_rpt = 1'b0;
        if (!btn) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    evt     = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(1);
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_HIT) begin
                        evt     = 1'b1;
                        evt_rpt = 1'b1;
                        state_d = ST_REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (cnt_q == RATE_HIT) begin
                        evt     = 1'b1;
                        evt_rpt = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_event_scheduler.sv
// Button event scheduler: per-button repeat FSMs feed one-deep pending slots,
// drained lowest index first into a valid/ready output register.
module btn_event_scheduler
    import fpww_pkg::*;
#(
    parameter int N_BTN    = DEF_N_BTN,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int RATE_CYC = DEF_RATE_CYC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             uclock,
    input  logic             uresetn,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [1:0]       evt_id,
    output logic             evt_rpt,
    output logic [7:0]       drop_cnt
);

    logic [N_BTN-1:0] fsm_evt, fsm_rpt;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_repeat_fsm #(
            .HOLD_CYC (HOLD_CYC),
            .RATE_CYC (RATE_CYC),
            .CNT_W    (CNT_W)
        ) u_fsm (
            .uclock  (uclock),
            .uresetn (uresetn),
            .btn     (btn_in[g]),
            .evt     (fsm_evt[g]),
            .evt_rpt (fsm_rpt[g])
        );
    end

    logic [N_BTN-1:0] p_vld_q, p_vld_d;
    logic [N_BTN-1:0] p_rpt_q, p_rpt_d;
    logic             evt_valid_q, evt_valid_d;
    logic [1:0]       evt_id_q, evt_id_d;
    logic             evt_rpt_q, evt_rpt_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic             load;
    logic [N_BTN-1:0] clr;
    logic [1:0]       sel_id;
    logic             sel_rpt;
    logic             drop_any;

    always_ff @(posedge uclock or negedge uresetn) begin
        if (!uresetn) begin
            p_vld_q     <= '0;
            p_rpt_q     <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= 2'd0;
            evt_rpt_q   <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            p_vld_q     <= p_vld_d;
            p_rpt_q     <= p_rpt_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_rpt_q   <= evt_rpt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_comb begin
        load        = !evt_valid_q || evt_ready;
        clr         = '0;
        sel_id      = 2'd0;
        sel_rpt     = 1'b0;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_rpt_d   = evt_rpt_q;
        drop_any    = 1'b0;
        p_vld_d     = p_vld_q;
        p_rpt_d     = p_rpt_q;

        // Scan downward so the lowest pending index is the one left selected.
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (p_vld_q[i]) begin
                sel_id  = 2'(i);
                sel_rpt = p_rpt_q[i];
            end
        end

        if (load) begin
            evt_valid_d = |p_vld_q;
            if (|p_vld_q) begin
                evt_id_d  = sel_id;
                evt_rpt_d = sel_rpt;
                clr       = N_BTN'(1) << sel_id;
            end
        end

        // A slot freed by this cycle's load can accept a new event at once.
        for (int i = 0; i < N_BTN; i++) begin
            p_vld_d[i] = p_vld_q[i] & ~clr[i];
            if (fsm_evt[i]) begin
                if (!p_vld_q[i] || clr[i]) begin
                    p_vld_d[i] = 1'b1;
                    p_rpt_d[i] = fsm_rpt[i];
                end else begin
                    drop_any = 1'b1;
                end
            end
        end

        drop_cnt_d = drop_any ? sat_inc8(drop_cnt_q) : drop_cnt_q;
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_rpt   = evt_rpt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Directed bench for btn_event_scheduler with HOLD_CYC=8, RATE_CYC=4, N_BTN=3.
module tb_btn_event_scheduler;

    logic       uclock;
    logic       uresetn;
    logic [2:0] btn_in;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_rpt;
    logic [7:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    btn_event_scheduler #(
        .N_BTN    (3),
        .HOLD_CYC (8),
        .RATE_CYC (4),
        .CNT_W    (8)
    ) dut (
        .uclock    (uclock),
        .uresetn   (uresetn),
        .btn_in    (btn_in),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_rpt   (evt_rpt),
        .drop_cnt  (drop_cnt)
    );

    initial uclock = 1'b0;
    always #5 uclock = ~uclock;

    initial begin
        #1000000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic tick();
        @(posedge uclock);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] b, input logic r);
        btn_in    = b;
        evt_ready = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        uresetn = 1'b0;
        applyStimulus(3'b000, 1'b0);
        tick();
        tick();
        uresetn = 1'b1;
    endtask

    initial begin
        logic exp_v;
        uresetn = 1'b1;
        applyStimulus(3'b000, 1'b0);
        #1 uresetn = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(evt_valid), 32'd0);
        checkOutput("rst_id", 32'(evt_id), 32'd0);
        checkOutput("rst_rpt", 32'(evt_rpt), 32'd0);
        checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
        doReset();

        // Single press held for 21 samples, consumer always ready.
        applyStimulus(3'b001, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            if (k == 22) applyStimulus(3'b000, 1'b1);
            tick();
            exp_v = (k == 2 || k == 10 || k == 14 || k == 18 || k == 22);
            checkOutput("single_valid", 32'(evt_valid), 32'(exp_v));
            if (exp_v) begin
                checkOutput("single_id", 32'(evt_id), 32'd0);
                checkOutput("single_rpt", 32'(evt_rpt), 32'(k != 2));
            end
        end

        // Short tap on button 1.
        doReset();
        applyStimulus(3'b010, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            if (k == 4) applyStimulus(3'b000, 1'b1);
            tick();
            checkOutput("tap_valid", 32'(evt_valid), 32'(k == 2));
            if (k == 2) begin
                checkOutput("tap_id", 32'(evt_id), 32'd1);
                checkOutput("tap_rpt", 32'(evt_rpt), 32'd0);
            end
        end

        // Simultaneous press: delivered in index order on consecutive cycles.
        doReset();
        applyStimulus(3'b111, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) applyStimulus(3'b000, 1'b1);
            tick();
            exp_v = (k >= 2 && k <= 4);
            checkOutput("simul_valid", 32'(evt_valid), 32'(exp_v));
            if (exp_v) begin
                checkOutput("simul_id", 32'(evt_id), 32'(k - 2));
                checkOutput("simul_rpt", 32'(evt_rpt), 32'd0);
            end
        end

        // New event in the same cycle its pending slot is drained: set wins.
        doReset();
        applyStimulus(3'b001, 1'b0); tick();
        applyStimulus(3'b000, 1'b0); tick();
        checkOutput("setwin_first_valid", 32'(evt_valid), 32'd1);
        applyStimulus(3'b010, 1'b0); tick();
        applyStimulus(3'b001, 1'b0); tick();
        applyStimulus(3'b000, 1'b0); tick();
        checkOutput("setwin_frozen_id", 32'(evt_id), 32'd0);
        applyStimulus(3'b001, 1'b1); tick();
        checkOutput("setwin_e6_id", 32'(evt_id), 32'd0);
        applyStimulus(3'b000, 1'b1); tick();
        checkOutput("setwin_e7_valid", 32'(evt_valid), 32'd1);
        checkOutput("setwin_e7_id", 32'(evt_id), 32'd0);
        tick();
        checkOutput("setwin_e8_id", 32'(evt_id), 32'd1);
        tick();
        checkOutput("setwin_e9_valid", 32'(evt_valid), 32'd0);
        checkOutput("setwin_drop", 32'(drop_cnt), 32'd0);

        // Two buttons dropping in one cycle count as a single drop.
        doReset();
        applyStimulus(3'b111, 1'b0); tick();
        applyStimulus(3'b000, 1'b0); tick();
        checkOutput("multi_valid", 32'(evt_valid), 32'd1);
        applyStimulus(3'b111, 1'b0); tick();
        checkOutput("multi_drop", 32'(drop_cnt), 32'd1);
        applyStimulus(3'b000, 1'b0); tick();
        checkOutput("multi_drop_hold", 32'(drop_cnt), 32'd1);

        // Backpressure while button 0 is held through three repeats.
        doReset();
        applyStimulus(3'b001, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k >= 2) begin
                checkOutput("bp_valid", 32'(evt_valid), 32'd1);
                checkOutput("bp_id", 32'(evt_id), 32'd0);
                checkOutput("bp_rpt", 32'(evt_rpt), 32'd0);
            end
        end
        applyStimulus(3'b000, 1'b0); tick();
        checkOutput("bp_drop", 32'(drop_cnt), 32'd2);
        applyStimulus(3'b000, 1'b1); tick();
        checkOutput("bp_rel_valid", 32'(evt_valid), 32'd1);
        checkOutput("bp_rel_rpt", 32'(evt_rpt), 32'd1);
        tick();
        checkOutput("bp_after_valid", 32'(evt_valid), 32'd0);
        tick();
        checkOutput("bp_after2_valid", 32'(evt_valid), 32'd0);
        checkOutput("bp_drop_final", 32'(drop_cnt), 32'd2);

        // Drop counter saturation from repeated taps against a full slot.
        doReset();
        for (int n = 1; n <= 330; n++) begin
            applyStimulus(3'b001, 1'b0); tick();
            applyStimulus(3'b000, 1'b0); tick();
            if (n == 100) checkOutput("sat_mid", 32'(drop_cnt), 32'd98);
        end
        checkOutput("sat_final", 32'(drop_cnt), 32'd255);

        // Asynchronous reset with button 2 repeating and an event presented.
        doReset();
        applyStimulus(3'b100, 1'b0);
        for (int k = 1; k <= 14; k++) tick();
        checkOutput("arst_pre_valid", 32'(evt_valid), 32'd1);
        checkOutput("arst_pre_id", 32'(evt_id), 32'd2);
        checkOutput("arst_pre_drop", 32'(drop_cnt), 32'd1);
        #1 uresetn = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(evt_valid), 32'd0);
        checkOutput("arst_id", 32'(evt_id), 32'd0);
        checkOutput("arst_drop", 32'(drop_cnt), 32'd0);
        #1 uresetn = 1'b1;
        tick();
        checkOutput("arst_e1_valid", 32'(evt_valid), 32'd0);
        tick();
        checkOutput("arst_e2_valid", 32'(evt_valid), 32'd1);
        checkOutput("arst_e2_id", 32'(evt_id), 32'd2);
        checkOutput("arst_e2_rpt", 32'(evt_rpt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
